// File: rtl/alu_pkg.sv
// ----------------------------------------------------------------------------
// alu_pkg: opcode constants, sequencer state enum and opcode legality check
//          shared by the ALU and alu_cmd_sequencer.  Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package alu_pkg;

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_MUL  = 4'b0011;
  localparam logic [3:0] OP_DIV  = 4'b0111;
  localparam logic [3:0] OP_AND  = 4'b1111;
  localparam logic [3:0] OP_OR   = 4'b1000;
  localparam logic [3:0] OP_NOT  = 4'b1001;
  localparam logic [3:0] OP_NAND = 4'b1011;
  localparam logic [3:0] OP_NOR  = 4'b1010;
  localparam logic [3:0] OP_XOR  = 4'b1100;
  localparam logic [3:0] OP_XNOR = 4'b1101;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    RESULT = 2'd2
  } seq_state_t;

  function automatic logic is_legal_op(input logic [3:0] op);
    case (op)
      4'b0010, 4'b0100, 4'b0101, 4'b0110, 4'b1110: is_legal_op = 1'b0;
      default:                                     is_legal_op = 1'b1;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/alu_cmd_sequencer.sv
// ----------------------------------------------------------------------------
// alu_cmd_sequencer: drives an external combinational ALU, waits SETTLE_CYCLES,
// returns the result. Option macro: ALU_CMD_SEQUENCER_CHAIN_EN.  Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module alu_cmd_sequencer
  import alu_pkg::*;
#(
  parameter int SETTLE_CYCLES = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [3:0] cmd_op,
  input  logic [3:0] cmd_a,
  input  logic [3:0] cmd_b,
`ifdef ALU_CMD_SEQUENCER_CHAIN_EN
  input  logic       cmd_chain,
`endif
  output logic [3:0] alu_op,
  output logic [3:0] alu_a,
  output logic [3:0] alu_b,
  input  logic [7:0] alu_r,
  output logic       res_valid,
  input  logic       res_ready,
  output logic [7:0] res_data,
  output logic [3:0] res_op,
  output logic       res_err,
  output logic [7:0] err_count
);

  localparam logic [3:0] CNT_LOAD = 4'(SETTLE_CYCLES - 1);

  seq_state_t state, state_n;
  logic [3:0] cnt, cnt_n;
  logic [3:0] alu_op_n, alu_a_n, alu_b_n, res_op_n;
  logic [7:0] res_data_n, err_count_n;
  logic       res_err_n, err_inc;
  logic [3:0] op_a;

`ifdef ALU_CMD_SEQUENCER_CHAIN_EN
  // Low nibble of the most recent non-error result, substituted for cmd_a.
  logic [3:0] chain_nib, chain_nib_n;
  assign op_a = cmd_chain ? chain_nib : cmd_a;
`else
  assign op_a = cmd_a;
`endif

  assign cmd_ready = rst_n && (state == IDLE);
  assign res_valid = (state == RESULT);

  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    alu_op_n   = alu_op;
    alu_a_n    = alu_a;
    alu_b_n    = alu_b;
    res_data_n = res_data;
    res_op_n   = res_op;
    res_err_n  = res_err;
    err_inc    = 1'b0;
`ifdef ALU_CMD_SEQUENCER_CHAIN_EN
    chain_nib_n = chain_nib;
`endif
    case (state)
      IDLE: begin
        if (cmd_valid && cmd_ready) begin
          alu_op_n = cmd_op;
          alu_a_n  = op_a;
          alu_b_n  = cmd_b;
          res_op_n = cmd_op;
          if (!is_legal_op(cmd_op)) begin
            res_data_n = 8'h00;
            res_err_n  = 1'b1;
            err_inc    = 1'b1;
            state_n    = RESULT;
          end else if (cmd_op == OP_DIV && cmd_b == 4'd0) begin
            // Divide-by-zero never reaches the ALU result path.
            res_data_n = 8'hFF;
            res_err_n  = 1'b1;
            err_inc    = 1'b1;
            state_n    = RESULT;
          end else begin
            cnt_n   = CNT_LOAD;
            state_n = SETTLE;
          end
        end
      end
      SETTLE: begin
        if (cnt == 4'd0) begin
          res_data_n = alu_r;
          res_err_n  = 1'b0;
          state_n    = RESULT;
`ifdef ALU_CMD_SEQUENCER_CHAIN_EN
          chain_nib_n = alu_r[3:0];
`endif
        end else begin
          cnt_n = cnt - 4'd1;
        end
      end
      RESULT: begin
        if (res_ready) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
    err_count_n = (err_inc && err_count != 8'hFF) ? err_count + 8'd1 : err_count;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      alu_op    <= 4'd0;
      alu_a     <= 4'd0;
      alu_b     <= 4'd0;
      res_data  <= 8'd0;
      res_op    <= 4'd0;
      res_err   <= 1'b0;
      err_count <= 8'd0;
`ifdef ALU_CMD_SEQUENCER_CHAIN_EN
      chain_nib <= 4'd0;
`endif
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      alu_op    <= alu_op_n;
      alu_a     <= alu_a_n;
      alu_b     <= alu_b_n;
      res_data  <= res_data_n;
      res_op    <= res_op_n;
      res_err   <= res_err_n;
      err_count <= err_count_n;
`ifdef ALU_CMD_SEQUENCER_CHAIN_EN
      chain_nib <= chain_nib_n;
`endif
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_alu_cmd_sequencer.sv
// ----------------------------------------------------------------------------
// tb_alu_cmd_sequencer: directed + random commands against a behavioural model,
// with a behavioural ALU beside the DUT.  Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_alu_cmd_sequencer;
  import alu_pkg::*;

  localparam int SETTLE = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       res_ready = 1'b0;
  logic [3:0] cmd_op = 4'd0, cmd_a = 4'd0, cmd_b = 4'd0;
  logic       chain_sel = 1'b0;
  logic       cmd_ready, res_valid, res_err;
  logic [3:0] alu_op, alu_a, alu_b, res_op;
  logic [7:0] alu_r, res_data, err_count;

  int n_assert = 0;
  int n_fail   = 0;
  int err_model = 0;
  logic [3:0] last_good = 4'd0;

  always #5 clk = ~clk;

  function automatic logic [7:0] alu_model(input logic [3:0] op, input logic [3:0] a, input logic [3:0] b);
    case (op)
      OP_ADD:  return 8'(a) + 8'(b);
      OP_SUB:  return 8'(a) - 8'(b);
      OP_MUL:  return 8'(a) * 8'(b);
      OP_DIV:  return (b == 4'd0) ? 8'hEE : 8'(a) / 8'(b);
      OP_AND:  return {4'h0, a & b};
      OP_OR:   return {4'h0, a | b};
      OP_NOT:  return {4'h0, ~a};
      OP_NAND: return {4'h0, ~(a & b)};
      OP_NOR:  return {4'h0, ~(a | b)};
      OP_XOR:  return {4'h0, a ^ b};
      OP_XNOR: return {4'h0, ~(a ^ b)};
      default: return 8'h5A;
    endcase
  endfunction

  assign alu_r = alu_model(alu_op, alu_a, alu_b);

  function automatic logic is_illegal(input logic [3:0] op);
    logic [3:0] bad_ops [5];
    bad_ops = '{4'd2, 4'd4, 4'd5, 4'd6, 4'd14};
    foreach (bad_ops[i]) if (bad_ops[i] == op) return 1'b1;
    return 1'b0;
  endfunction

  alu_cmd_sequencer #(.SETTLE_CYCLES(SETTLE)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_a     (cmd_a),
    .cmd_b     (cmd_b),
`ifdef ALU_CMD_SEQUENCER_CHAIN_EN
    .cmd_chain (chain_sel),
`endif
    .alu_op    (alu_op),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_r     (alu_r),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .res_op    (res_op),
    .res_err   (res_err),
    .err_count (err_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full command: issue, measure latency, check result, hold, handshake.
  task automatic run_cmd(input logic [3:0] op, input logic [3:0] a, input logic [3:0] b,
                         input logic ch, input int hold);
    logic [3:0] a_eff;
    logic       bad, dz;
    logic [7:0] exp_data;
    int         exp_lat, lat;
    a_eff    = ch ? last_good : a;
    bad      = is_illegal(op);
    dz       = !bad && (op == OP_DIV) && (b == 4'd0);
    exp_data = bad ? 8'h00 : (dz ? 8'hFF : alu_model(op, a_eff, b));
    exp_lat  = (bad || dz) ? 1 : SETTLE + 1;

    chk("ready_idle", {31'd0, cmd_ready}, 32'd1);
    cmd_valid = 1'b1; cmd_op = op; cmd_a = a; cmd_b = b; chain_sel = ch;
    tick();
    cmd_valid = 1'b0; chain_sel = 1'b0;
    chk("alu_op", {28'd0, alu_op}, {28'd0, op});
    chk("alu_a",  {28'd0, alu_a},  {28'd0, a_eff});
    chk("alu_b",  {28'd0, alu_b},  {28'd0, b});

    lat = 1;
    while (!res_valid && lat < 40) begin
      chk("ready_busy", {31'd0, cmd_ready}, 32'd0);
      tick();
      lat++;
    end
    chk("latency", lat, exp_lat);

    if (bad || dz) begin
      if (err_model < 255) err_model++;
    end else begin
      last_good = exp_data[3:0];
    end
    chk("res_data",  {24'd0, res_data},  {24'd0, exp_data});
    chk("res_op",    {28'd0, res_op},    {28'd0, op});
    chk("res_err",   {31'd0, res_err},   {31'd0, (bad || dz)});
    chk("err_count", {24'd0, err_count}, err_model);
    chk("ready_res", {31'd0, cmd_ready}, 32'd0);

    // A competing command stays asserted through the hold and the handshake.
    cmd_valid = 1'b1; cmd_op = ~op; cmd_a = ~a; cmd_b = ~b;
    repeat (hold) tick();
    if (hold > 0) begin
      chk("hold_valid", {31'd0, res_valid}, 32'd1);
      chk("hold_data",  {24'd0, res_data},  {24'd0, exp_data});
      chk("hold_op",    {28'd0, res_op},    {28'd0, op});
      chk("hold_err",   {31'd0, res_err},   {31'd0, (bad || dz)});
    end
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    cmd_valid = 1'b0;
    chk("valid_drop", {31'd0, res_valid}, 32'd0);
    chk("bubble_op",  {28'd0, alu_op},    {28'd0, op});
    chk("ready_back", {31'd0, cmd_ready}, 32'd1);
  endtask

  initial begin
    // Reset state
    rst_n = 1'b0;
    tick();
    tick();
    chk("rst_ready", {31'd0, cmd_ready}, 32'd0);
    chk("rst_valid", {31'd0, res_valid}, 32'd0);
    chk("rst_alu",   {20'd0, alu_op, alu_a, alu_b}, 32'd0);
    chk("rst_res",   {19'd0, res_err, res_op, res_data}, 32'd0);
    chk("rst_errc",  {24'd0, err_count}, 32'd0);
    rst_n = 1'b1;
    #1;
    chk("rel_ready", {31'd0, cmd_ready}, 32'd1);

    // Directed commands
    run_cmd(OP_ADD, 4'd7, 4'd9, 1'b0, 0);
    chk("add_7_9", {24'd0, res_data}, 32'h10);
    run_cmd(OP_MUL, 4'd15, 4'd15, 1'b0, 0);
    chk("mul_15_15", {24'd0, res_data}, 32'hE1);
    run_cmd(OP_DIV, 4'd9, 4'd0, 1'b0, 0);
    chk("div0_errc", {24'd0, err_count}, 32'd1);
    run_cmd(4'b0110, 4'd3, 4'd3, 1'b0, 0);
    chk("ill_errc", {24'd0, err_count}, 32'd2);
    run_cmd(OP_SUB, 4'd2, 4'd5, 1'b0, 10);
    run_cmd(OP_XNOR, 4'hA, 4'h6, 1'b0, 2);

`ifdef ALU_CMD_SEQUENCER_CHAIN_EN
    run_cmd(OP_ADD, 4'd4, 4'd5, 1'b0, 0);
    run_cmd(OP_ADD, 4'd7, 4'd2, 1'b1, 0);
    chk("chain_add", {24'd0, res_data}, 32'h0B);
`endif

    // Reset during SETTLE discards the command
    cmd_valid = 1'b1; cmd_op = OP_SUB; cmd_a = 4'd3; cmd_b = 4'd5;
    tick();
    cmd_valid = 1'b0;
    tick();
    rst_n = 1'b0;
    tick();
    err_model = 0;
    last_good = 4'd0;
    chk("mid_rst_valid", {31'd0, res_valid}, 32'd0);
    chk("mid_rst_ready", {31'd0, cmd_ready}, 32'd0);
    chk("mid_rst_alu",   {20'd0, alu_op, alu_a, alu_b}, 32'd0);
    chk("mid_rst_res",   {19'd0, res_err, res_op, res_data}, 32'd0);
    chk("mid_rst_errc",  {24'd0, err_count}, 32'd0);
    rst_n = 1'b1;
    #1;
    chk("mid_rel_ready", {31'd0, cmd_ready}, 32'd1);
    repeat (SETTLE + 2) begin
      tick();
      chk("no_stale_res", {31'd0, res_valid}, 32'd0);
    end

    // Random commands
    for (int i = 0; i < 60; i++) begin
      logic [3:0] op, a, b;
      logic       ch;
      op = 4'($urandom_range(0, 15));
      a  = 4'($urandom_range(0, 15));
      b  = ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
      ch = 1'b0;
`ifdef ALU_CMD_SEQUENCER_CHAIN_EN
      ch = 1'($urandom_range(0, 1));
`endif
      run_cmd(op, a, b, ch, int'($urandom_range(0, 3)));
    end

    // Error counter saturation
    for (int i = 0; i < 260; i++) begin
      run_cmd(4'b1110, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 1'b0, 0);
    end
    chk("errc_sat", {24'd0, err_count}, 32'hFF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/alu_cmd_sequencer.md
ALU_CMD_SEQUENCER -- requirements
Module: alu_cmd_sequencer

Interface
REQ-001 Parameter SETTLE_CYCLES, default 1, sets the cycles alu_a/alu_b/alu_op are held stable before alu_r is sampled; legal range 1..15.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 cmd_valid  input  1  command present.
REQ-005 cmd_ready  output  1  sequencer can accept a command.
REQ-006 cmd_op  input  4  opcode (ADD 0000, SUB 0001, MUL 0011, DIV 0111, AND 1111, OR 1000, NOT 1001, NAND 1011, NOR 1010, XOR 1100, XNOR 1101).
REQ-007 cmd_a, cmd_b  input  4 each  operands.
REQ-008 alu_op, alu_a, alu_b  output  4 each  registered drive to the combinational ALU.
REQ-009 alu_r  input  8  ALU result.
REQ-010 res_valid  output  1  result present; res_ready  input  1  consumer accepts.
REQ-011 res_data  output  8; res_op  output  4 (echoed opcode); res_err  output  1 (result invalid).
REQ-012 err_count  output  8  saturating count of error results.

Function
REQ-013 The FSM SHALL have exactly three states: IDLE, SETTLE, RESULT.
REQ-014 In IDLE, cmd_ready SHALL be 1; cmd_ready SHALL be 0 in every other state.
REQ-015 A command SHALL be accepted on an edge where cmd_valid&&cmd_ready; cmd_op/cmd_a/cmd_b are latched into alu_op/alu_a/alu_b on that edge.
REQ-016 Legal non-DIV opcodes, and DIV with cmd_b!=0: IDLE->SETTLE; a down-counter loaded with SETTLE_CYCLES-1 decrements each cycle; on the edge where it is 0, alu_r is latched into res_data, res_err=0, state->RESULT.
REQ-017 End-to-end latency for a legal command: res_valid SHALL rise exactly SETTLE_CYCLES+1 cycles after the accepting edge.
REQ-018 Illegal opcode (0010, 0100, 0101, 0110, 1110): IDLE->RESULT directly, res_data=8'h00, res_err=1; alu_* outputs SHALL still be updated.
REQ-019 DIV with cmd_b==0: IDLE->RESULT directly, res_data=8'hFF, res_err=1; alu_r SHALL NOT be sampled.
REQ-020 RESULT: res_valid=1, and res_data/res_op/res_err SHALL be stable until res_valid&&res_ready; on that edge state->IDLE.
REQ-021 A command SHALL NOT be accepted on the res_ready handshake edge; the earliest next acceptance is the following edge (one bubble).
REQ-022 alu_op/alu_a/alu_b SHALL hold their last values in IDLE and RESULT.
REQ-023 err_count SHALL increment by 1 on each edge entering RESULT with res_err=1, saturating at 8'hFF.

Reset
REQ-024 With rst_n=0 at an edge: state=IDLE, alu_op/alu_a/alu_b=0, res_data=0, res_op=0, res_err=0, res_valid=0, err_count=0, counter=0.
REQ-025 Reset asserted in SETTLE or RESULT SHALL discard the in-flight command with no result emitted.
REQ-026 cmd_ready SHALL be 0 while rst_n=0 and SHALL be 1 on the first cycle after release.

Configuration
REQ-027 Macro ALU_CMD_SEQUENCER_CHAIN_EN, when defined, SHALL add input cmd_chain (1 bit); a command accepted with cmd_chain=1 SHALL use the low nibble of the last non-error res_data (0 after reset) in place of cmd_a.
REQ-028 Without ALU_CMD_SEQUENCER_CHAIN_EN, cmd_chain SHALL NOT exist and cmd_a SHALL always be used.

Structure
REQ-029 A shared package alu_pkg SHALL hold the 4-bit opcode constants, the FSM state enum, and an is_legal_op function; the ALU and this block SHALL both use it.
REQ-030 No sub-module; the ALU SHALL be instantiated beside this block by the enclosing level, not inside it.

Verification
REQ-031 SETTLE_CYCLES=1, ADD a=7 b=9 -> res_data=8'h10, res_err=0, res_valid exactly 2 cycles after acceptance.
REQ-032 SETTLE_CYCLES=3, MUL a=15 b=15 -> res_data=8'hE1 four cycles after acceptance; cmd_ready=0 throughout.
REQ-033 DIV a=9 b=0 -> res_data=8'hFF, res_err=1 next cycle, err_count 0->1; opcode 0110 -> res_data=8'h00, res_err=1, err_count 1->2.
REQ-034 Hold res_ready=0 for 10 cycles in RESULT -> res_data/res_op/res_err stable, no second command accepted despite cmd_valid=1.
REQ-035 rst_n=0 during SETTLE of SUB a=3 b=5 -> no res_valid, all outputs per REQ-024, cmd_ready=1 first cycle after release.
REQ-036 With ALU_CMD_SEQUENCER_CHAIN_EN: ADD 4+5 (res 8'h09), then chained ADD b=2 -> res_data=8'h0B.
